// File: rtl/execute_stage_if.sv
// Decode-to-execute handshake and execute result bundle.
// Decode side is the master; the execute stage is the slave.
interface execute_stage_if;
  logic [180:0] ID_EX;
  logic         id_valid;
  logic         stall;
  logic [71:0]  EX_MEM;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic         halted;

  modport master (
    output ID_EX,
    output id_valid,
    input  stall,
    input  EX_MEM,
    input  branch_taken,
    input  branch_target,
    input  halted
  );

  modport slave (
    input  ID_EX,
    input  id_valid,
    output stall,
    output EX_MEM,
    output branch_taken,
    output branch_target,
    output halted
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU, shift, branch resolve, iterative multiply, halt.
// MUL runs 32 shift-add steps while back-pressuring decode via stall.
module execute_stage (
  input  logic           clock,
  input  logic           reset_n,
  execute_stage_if.slave ex
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MUL  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t r_state, w_state_nx;

  logic [31:0] w_pc, w_rs, w_rt, w_simm;
  logic [4:0]  w_rd, w_sh;
  logic [10:0] w_off;
  logic [15:0] w_op;
  logic [14:0] w_sel;
  logic        w_legal;
  logic        w_unused;

  assign w_pc     = ex.ID_EX[31:0];
  assign w_rs     = ex.ID_EX[63:32];
  assign w_rt     = ex.ID_EX[95:64];
  assign w_rd     = ex.ID_EX[100:96];
  assign w_off    = ex.ID_EX[111:101];
  assign w_simm   = ex.ID_EX[159:128];
  assign w_op     = ex.ID_EX[175:160];
  assign w_sh     = ex.ID_EX[180:176];
  assign w_unused = ^ex.ID_EX[127:112];

  // Anything but a single legal opcode bit collapses to NOP
  assign w_legal = $onehot(w_op) & ~w_op[15];
  assign w_sel   = w_legal ? w_op[14:0] : 15'h4000;

  logic [31:0] w_res, w_tgt;
  logic        w_wen, w_br, w_mul, w_hlt;

  assign w_tgt = w_pc + {{21{w_off[10]}}, w_off};

  always_comb begin
    w_res = '0;
    w_wen = 1'b0;
    w_br  = 1'b0;
    w_mul = 1'b0;
    w_hlt = 1'b0;
    unique case (1'b1)
      w_sel[0]:  begin w_res = w_rs + w_rt;   w_wen = 1'b1; end
      w_sel[1]:  begin w_res = w_rs - w_rt;   w_wen = 1'b1; end
      w_sel[2]:  begin w_res = w_simm;        w_wen = 1'b1; end
      w_sel[3]:  begin w_res = w_rs << w_sh;  w_wen = 1'b1; end
      w_sel[4]:  begin w_res = w_rs >> w_sh;  w_wen = 1'b1; end
      w_sel[5]:  begin w_res = w_rs & w_rt;   w_wen = 1'b1; end
      w_sel[6]:  begin w_res = w_rs | w_rt;   w_wen = 1'b1; end
      w_sel[7]:  begin w_res = w_rs ^ w_rt;   w_wen = 1'b1; end
      w_sel[8]:  w_br = 1'b1;
      w_sel[9]:  w_br = (w_rs != w_rt);
      w_sel[10]: begin w_res = w_rs;          w_wen = 1'b1; end
      w_sel[11]: begin w_res = w_rs + w_simm; w_wen = 1'b1; end
      w_sel[12]: w_mul = 1'b1;
      w_sel[13]: w_hlt = 1'b1;
      w_sel[14]: ;
      default:   ;
    endcase
  end

  logic w_acc;
  assign w_acc = ex.id_valid & (r_state == S_RUN);

  logic [31:0] r_mcand, r_mplier, r_acc, r_mpc;
  logic [4:0]  r_mrd, r_cnt;
  logic [31:0] w_acc_nx;
  logic        w_mul_done;

  assign w_acc_nx   = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == 5'd31);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_acc && w_mul)      w_state_nx = S_MUL;
        else if (w_acc && w_hlt) w_state_nx = S_HALT;
      end
      S_MUL:   if (w_mul_done) w_state_nx = S_RUN;
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_RUN;
    endcase
  end

  always_comb begin
    ex.stall  = (r_state != S_RUN);
    ex.halted = (r_state == S_HALT);
  end

  logic [31:0] r_res, r_pc, r_btgt;
  logic [4:0]  r_rd;
  logic        r_wen, r_valid, r_halt, r_btk;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_res    <= '0;
      r_pc     <= '0;
      r_rd     <= '0;
      r_wen    <= 1'b0;
      r_valid  <= 1'b0;
      r_halt   <= 1'b0;
      r_btk    <= 1'b0;
      r_btgt   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mpc    <= '0;
      r_mrd    <= '0;
      r_cnt    <= '0;
    end else begin
      r_wen   <= 1'b0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_btk   <= 1'b0;
      if (w_acc && w_mul) begin
        r_mcand  <= w_rs;
        r_mplier <= w_rt;
        r_mpc    <= w_pc;
        r_mrd    <= w_rd;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_acc) begin
        r_res   <= w_res;
        r_pc    <= w_pc;
        r_rd    <= w_rd;
        r_wen   <= w_wen;
        r_valid <= 1'b1;
        r_halt  <= w_hlt;
        r_btk   <= w_br;
        if (w_br) r_btgt <= w_tgt;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_nx;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 5'd1;
        if (w_mul_done) begin
          r_res   <= w_acc_nx;
          r_pc    <= r_mpc;
          r_rd    <= r_mrd;
          r_wen   <= 1'b1;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign ex.EX_MEM        = {r_halt, r_valid, r_wen, r_rd, r_pc, r_res};
  assign ex.branch_taken  = r_btk;
  assign ex.branch_target = r_btgt;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

  logic clock;
  logic reset_n;
  int   n_chk;
  int   n_err;

  execute_stage_if ex_if ();

  execute_stage dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ex      (ex_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [15:0] OP_ADD = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0002;
  localparam logic [15:0] OP_LI  = 16'h0004;
  localparam logic [15:0] OP_SHL = 16'h0008;
  localparam logic [15:0] OP_SHR = 16'h0010;
  localparam logic [15:0] OP_BR  = 16'h0100;
  localparam logic [15:0] OP_BNE = 16'h0200;
  localparam logic [15:0] OP_ADI = 16'h0800;
  localparam logic [15:0] OP_MUL = 16'h1000;
  localparam logic [15:0] OP_HLT = 16'h2000;

  function automatic logic [180:0] mk(
    input logic [15:0] op,
    input logic [31:0] pc,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [4:0]  rd,
    input logic [10:0] off,
    input logic [15:0] imm,
    input logic [4:0]  sh
  );
    return {sh, op, {{16{imm[15]}}, imm}, imm, off, rd, rt, rs, pc};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exec(input logic [180:0] id);
    @(negedge clock);
    ex_if.ID_EX    = id;
    ex_if.id_valid = 1'b1;
    @(negedge clock);
    ex_if.id_valid = 1'b0;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic [31:0] res,
    input logic        wen
  );
    check({tag, " res"},   ex_if.EX_MEM[31:0], res);
    check({tag, " wen"},   {31'd0, ex_if.EX_MEM[69]}, {31'd0, wen});
    check({tag, " valid"}, {31'd0, ex_if.EX_MEM[70]}, 32'd1);
  endtask

  int n;
  int nv;

  initial begin
    n_chk          = 0;
    n_err          = 0;
    reset_n        = 1'b0;
    ex_if.ID_EX    = '0;
    ex_if.id_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst exmem",  ex_if.EX_MEM[31:0], 32'd0);
    check("rst exhi",   {24'd0, ex_if.EX_MEM[71:64]}, 32'd0);
    check("rst stall",  {31'd0, ex_if.stall}, 32'd0);
    check("rst halted", {31'd0, ex_if.halted}, 32'd0);
    check("rst btk",    {31'd0, ex_if.branch_taken}, 32'd0);
    check("rst btgt",   ex_if.branch_target, 32'd0);
    reset_n = 1'b1;

    exec(mk(OP_ADD, 32'h10, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd3, 0, 0, 0));
    chk_out("add", 32'hAAAAAAA9, 1'b1);
    check("add rd", {27'd0, ex_if.EX_MEM[68:64]}, 32'd3);
    check("add pc", ex_if.EX_MEM[63:32], 32'h10);
    @(negedge clock);
    check("add pulse", {31'd0, ex_if.EX_MEM[70]}, 32'd0);
    exec(mk(OP_SUB, 32'h14, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd4, 0, 0, 0));
    chk_out("sub", 32'hAAAAAAAB, 1'b1);

    exec(mk(OP_MUL, 32'h20, 32'd7, 32'd6, 5'd5, 0, 0, 0));
    n  = 0;
    nv = 0;
    while (ex_if.stall && n < 100) begin
      if (ex_if.EX_MEM[70]) nv++;
      n++;
      @(negedge clock);
    end
    check("mul stall cyc", n, 32);
    check("mul busy valid", nv, 0);
    chk_out("mul 7x6", 32'h2A, 1'b1);
    check("mul rd", {27'd0, ex_if.EX_MEM[68:64]}, 32'd5);

    exec(mk(OP_MUL, 32'h24, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0, 0, 0));
    ex_if.ID_EX    = mk(OP_ADD, 32'h28, 32'd1, 32'd2, 5'd7, 0, 0, 0);
    ex_if.id_valid = 1'b1;
    n = 0;
    while (ex_if.stall && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("mul2 stall cyc", n, 32);
    chk_out("mul ffxff", 32'h1, 1'b1);
    @(negedge clock);
    ex_if.id_valid = 1'b0;
    chk_out("held add", 32'h3, 1'b1);
    check("held add rd", {27'd0, ex_if.EX_MEM[68:64]}, 32'd7);
    nv = 0;
    repeat (2) begin
      @(negedge clock);
      if (ex_if.EX_MEM[70]) nv++;
    end
    check("held add once", nv, 0);

    exec(mk(OP_BNE, 32'h100, 32'd5, 32'd5, 5'd1, 11'h010, 0, 0));
    chk_out("bne eq", 32'd0, 1'b0);
    check("bne eq btk", {31'd0, ex_if.branch_taken}, 32'd0);
    exec(mk(OP_BNE, 32'h100, 32'd5, 32'd6, 5'd1, 11'h7FF, 0, 0));
    check("bne ne btk", {31'd0, ex_if.branch_taken}, 32'd1);
    check("bne ne tgt", ex_if.branch_target, 32'hFF);
    check("bne ne wen", {31'd0, ex_if.EX_MEM[69]}, 32'd0);
    exec(mk(OP_BR, 32'h100, 32'd0, 32'd0, 5'd1, 11'h010, 0, 0));
    check("br btk", {31'd0, ex_if.branch_taken}, 32'd1);
    check("br tgt", ex_if.branch_target, 32'h110);
    @(negedge clock);
    check("br pulse", {31'd0, ex_if.branch_taken}, 32'd0);
    check("br tgt hold", ex_if.branch_target, 32'h110);

    exec(mk(OP_SHL, 32'h30, 32'h0000000F, 0, 5'd2, 0, 0, 5'd4));
    chk_out("shl", 32'hF0, 1'b1);
    exec(mk(OP_SHR, 32'h34, 32'h80000000, 0, 5'd2, 0, 0, 5'd31));
    chk_out("shr", 32'h1, 1'b1);
    exec(mk(OP_SHL, 32'h38, 32'h12345678, 0, 5'd2, 0, 0, 5'd0));
    chk_out("shl0", 32'h12345678, 1'b1);
    exec(mk(OP_LI, 32'h3C, 0, 0, 5'd2, 0, 16'h8000, 0));
    chk_out("li", 32'hFFFF8000, 1'b1);
    exec(mk(OP_ADI, 32'h40, 32'd1, 0, 5'd2, 0, 16'hFFFF, 0));
    chk_out("adi", 32'h0, 1'b1);

    exec(mk(16'h0000, 32'h44, 32'd9, 32'd9, 5'd2, 0, 0, 0));
    chk_out("op0000", 32'h0, 1'b0);
    exec(mk(16'h0003, 32'h48, 32'd9, 32'd9, 5'd2, 0, 0, 0));
    chk_out("op0003", 32'h0, 1'b0);
    exec(mk(16'h8000, 32'h4C, 32'd9, 32'd9, 5'd2, 0, 0, 0));
    chk_out("op8000", 32'h0, 1'b0);

    exec(mk(OP_ADD, 32'h50, 32'd8, 32'd8, 5'd9, 0, 0, 0));
    exec(mk(OP_MUL, 32'h54, 32'd3, 32'd3, 5'd9, 0, 0, 0));
    repeat (9) @(negedge clock);
    check("pre-rst stall", {31'd0, ex_if.stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mrst res",   ex_if.EX_MEM[31:0], 32'd0);
    check("mrst hi",    ex_if.EX_MEM[63:32], 32'd0);
    check("mrst stall", {31'd0, ex_if.stall}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clock);
      if (ex_if.EX_MEM[70]) nv++;
    end
    check("mrst no result", nv, 0);
    exec(mk(OP_ADD, 32'h58, 32'd100, 32'd23, 5'd10, 0, 0, 0));
    chk_out("post-rst add", 32'd123, 1'b1);

    exec(mk(OP_HLT, 32'h60, 0, 0, 5'd0, 0, 0, 0));
    check("hlt valid",  {31'd0, ex_if.EX_MEM[70]}, 32'd1);
    check("hlt halt",   {31'd0, ex_if.EX_MEM[71]}, 32'd1);
    check("hlt wen",    {31'd0, ex_if.EX_MEM[69]}, 32'd0);
    check("hlt halted", {31'd0, ex_if.halted}, 32'd1);
    check("hlt stall",  {31'd0, ex_if.stall}, 32'd1);
    ex_if.ID_EX    = mk(OP_ADD, 32'h64, 32'd1, 32'd1, 5'd1, 0, 0, 0);
    ex_if.id_valid = 1'b1;
    nv = 0;
    repeat (5) begin
      @(negedge clock);
      if (ex_if.EX_MEM[70] || ex_if.EX_MEM[71]) nv++;
    end
    ex_if.id_valid = 1'b0;
    check("halted no out", nv, 0);
    check("halted stays", {31'd0, ex_if.halted}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("hrst halted", {31'd0, ex_if.halted}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    exec(mk(OP_ADD, 32'h68, 32'd2, 32'd2, 5'd1, 0, 0, 0));
    chk_out("after halt", 32'd4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
